// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: controller state
// encoding, byte width and the transmitter's sample-tick constants.
package uart_pkg;

   localparam int BYTE_W = 8;

   // Transmitter oversampling: ticks per bit and the matching counter width.
   localparam int TX_OVERSAMPLE = 16;
   localparam int TX_TICK_W     = $clog2(TX_OVERSAMPLE);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SEND   = 3'd1,
      ST_WAIT   = 3'd2,
      ST_GAP    = 3'd3,
      ST_FINISH = 3'd4
   } state_t;

endpackage

// File: rtl/uart_block_tx_ctrl_if.sv
// Block-in / byte-out bundle between the block producer, the block
// transmit controller and the byte-wide UART transmitter.
interface uart_block_tx_ctrl_if #(
   parameter int NBYTES = 16
) ();

   logic                               blk_valid;
   logic [uart_pkg::BYTE_W*NBYTES-1:0] blk_data;
   logic                               blk_ready;
   logic                               tx_start;
   logic [uart_pkg::BYTE_W-1:0]        tx_data;
   logic                               tx_done;
   logic                               busy;
   logic [4:0]                         byte_idx;
   logic                               blk_done;
   logic                               timeout_err;

   // Controller side: drives the transmitter and the status outputs.
   modport master (
      input  blk_valid, blk_data, tx_done,
      output blk_ready, tx_start, tx_data, busy, byte_idx, blk_done, timeout_err
   );

   // Environment side: block producer plus transmitter.
   modport slave (
      output blk_valid, blk_data, tx_done,
      input  blk_ready, tx_start, tx_data, busy, byte_idx, blk_done, timeout_err
   );

endinterface

// File: rtl/uart_done_edge.sv
// Rising-edge detector for the transmitter's done line. The history
// register resets high so a line already high out of reset is not an event.
module uart_done_edge (
   input  logic clk,
   input  logic reset,
   input  logic done_i,
   output logic event_o
);

   logic done_q;

   // Registered copy of the done line for edge detection.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) done_q <= 1'b1;
      else        done_q <= done_i;
   end

   assign event_o = done_i & ~done_q;

endmodule

// File: rtl/uart_block_tx_ctrl.sv
// Feeds a multi-byte block into the byte-wide UART transmitter one byte
// at a time, waiting for each byte's done edge, with an optional inter-byte
// gap and a per-byte timeout that abandons the rest of the block.
module uart_block_tx_ctrl
   import uart_pkg::*;
#(
   parameter int NBYTES         = 16,
   parameter bit MSB_FIRST      = 1'b1,
   parameter int GAP_CYCLES     = 0,
   parameter int TIMEOUT_CYCLES = 1048576
) (
   input logic                 clk,
   input logic                 reset,
   uart_block_tx_ctrl_if.master bus
);

   localparam int                BLK_W    = BYTE_W * NBYTES;
   localparam int                TO_W     = $clog2(TIMEOUT_CYCLES);
   localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0]        GAP_LAST = 8'(GAP_CYCLES - 1);
   localparam logic [4:0]        IDX_LAST = 5'(NBYTES - 1);

   state_t              state_q, state_d;
   logic [BLK_W-1:0]    shreg_q, shreg_d;
   logic [4:0]          idx_q, idx_d;
   logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
   logic [7:0]          gap_cnt_q, gap_cnt_d;
   logic                tx_start_q, tx_start_d;
   logic [BYTE_W-1:0]   tx_data_q, tx_data_d;
   logic                blk_done_q, blk_done_d;
   logic                to_err_q, to_err_d;
   logic                done_evt;

   uart_done_edge u_done_edge (
      .clk     (clk),
      .reset   (reset),
      .done_i  (bus.tx_done),
      .event_o (done_evt)
   );

   function automatic logic [BYTE_W-1:0] head_byte(input logic [BLK_W-1:0] v);
      return MSB_FIRST ? v[BLK_W-1 -: BYTE_W] : v[BYTE_W-1:0];
   endfunction

   function automatic logic [BLK_W-1:0] advance(input logic [BLK_W-1:0] v);
      return MSB_FIRST ? (v << BYTE_W) : (v >> BYTE_W);
   endfunction

   // State, datapath and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         shreg_q    <= '0;
         idx_q      <= '0;
         to_cnt_q   <= '0;
         gap_cnt_q  <= '0;
         tx_start_q <= 1'b0;
         tx_data_q  <= '0;
         blk_done_q <= 1'b0;
         to_err_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         shreg_q    <= shreg_d;
         idx_q      <= idx_d;
         to_cnt_q   <= to_cnt_d;
         gap_cnt_q  <= gap_cnt_d;
         tx_start_q <= tx_start_d;
         tx_data_q  <= tx_data_d;
         blk_done_q <= blk_done_d;
         to_err_q   <= to_err_d;
      end
   end

   // Next-state logic; outputs are decoded from the next state so they
   // appear registered in the same cycle as the state they belong to.
   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      idx_d     = idx_q;
      to_cnt_d  = to_cnt_q;
      gap_cnt_d = gap_cnt_q;
      to_err_d  = to_err_q;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.blk_valid) begin
               shreg_d  = bus.blk_data;
               idx_d    = '0;
               to_err_d = 1'b0;
               state_d  = ST_SEND;
            end
         end
         ST_SEND: begin
            to_cnt_d = '0;
            state_d  = ST_WAIT;
         end
         ST_WAIT: begin
            to_cnt_d = to_cnt_q + 1'b1;
            if (done_evt) begin
               if (idx_q == IDX_LAST) begin
                  state_d = ST_FINISH;
               end else begin
                  shreg_d   = advance(shreg_q);
                  idx_d     = idx_q + 5'd1;
                  gap_cnt_d = '0;
                  state_d   = (GAP_CYCLES > 0) ? ST_GAP : ST_SEND;
               end
            end else if (to_cnt_q == TO_LAST) begin
               to_err_d = 1'b1;
               state_d  = ST_IDLE;
            end
         end
         ST_GAP: begin
            if (gap_cnt_q == GAP_LAST) state_d = ST_SEND;
            else                       gap_cnt_d = gap_cnt_q + 8'd1;
         end
         ST_FINISH: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
      tx_start_d = (state_d == ST_SEND);
      tx_data_d  = tx_start_d ? head_byte(shreg_d) : tx_data_q;
      blk_done_d = (state_d == ST_FINISH);
   end

   assign bus.blk_ready   = (state_q == ST_IDLE);
   assign bus.busy        = (state_q != ST_IDLE);
   assign bus.tx_start    = tx_start_q;
   assign bus.tx_data     = tx_data_q;
   assign bus.byte_idx    = idx_q;
   assign bus.blk_done    = blk_done_q;
   assign bus.timeout_err = to_err_q;

endmodule

// File: tb/tb_uart_block_tx_ctrl.sv
// Bench for uart_block_tx_ctrl: instance A (MSB first, no gap, short
// timeout) runs a table of blocks; instance B (LSB first, 3-cycle gap)
// runs one block. Transmitter models answer each start with a done pulse.
`timescale 1ns/1ps
module tb_uart_block_tx_ctrl;

   localparam int NB    = 16;
   localparam int TO_A  = 50;
   localparam int GAP_B = 3;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   always @(posedge clk) cyc <= cyc + 1;

   uart_block_tx_ctrl_if #(.NBYTES(NB)) ifa ();
   uart_block_tx_ctrl_if #(.NBYTES(NB)) ifb ();

   uart_block_tx_ctrl #(.NBYTES(NB), .MSB_FIRST(1'b1), .GAP_CYCLES(0), .TIMEOUT_CYCLES(TO_A))
      dut_a (.clk(clk), .reset(rst_n), .bus(ifa));
   uart_block_tx_ctrl #(.NBYTES(NB), .MSB_FIRST(1'b0), .GAP_CYCLES(GAP_B), .TIMEOUT_CYCLES(64))
      dut_b (.clk(clk), .reset(rst_n), .bus(ifb));

   typedef struct {
      logic [7:0] b;
      logic [4:0] idx;
   } exp_t;

   typedef struct {
      logic [127:0] data;
      int           drop;
      bit           held;
      int           exp_starts;
      int           exp_done;
      bit           exp_to;
      logic [7:0]   exp_first;
      logic [7:0]   exp_last;
   } vec_t;

   exp_t qa[$];
   exp_t qb[$];
   vec_t vecs[4];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- transmitter model A ----------------
   int a_drop = 99;
   bit a_held = 1'b0;
   int a_cnt = 0, a_hold = 0, a_cur = 0, a_last_done = -1;
   bit a_pend = 1'b0;

   initial begin
      ifa.tx_done = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            a_cnt = 0; a_hold = 0; a_pend = 1'b0; ifa.tx_done = 1'b0;
         end else begin
            if (a_hold > 0) begin
               a_hold--;
               if (a_hold == 0) ifa.tx_done = 1'b0;
            end else if (a_pend) begin
               ifa.tx_done = 1'b1;
               a_last_done = cyc;
               a_hold = (a_held && a_cur == 0) ? 20 : 1;
               a_pend = 1'b0;
            end
            if (a_cnt > 0) begin
               a_cnt--;
               if (a_cnt == 0) a_pend = 1'b1;
            end
            if (ifa.tx_start && int'(ifa.byte_idx) != a_drop) begin
               a_cnt = 9;
               a_cur = int'(ifa.byte_idx);
            end
         end
      end
   end

   // ---------------- monitor A ----------------
   int a_starts = 0, a_bdone = 0, a_acc = -1, a_last_start = -1, a_to_cyc = -1;
   int a_sc[NB];
   logic [7:0] a_first = '0, a_last = '0, a_hdata = '0;
   bit a_prev_bd = 1'b0, a_prev_to = 1'b0;

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (ifa.tx_start) begin
               a_starts++;
               if (qa.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL a_unexpected_start: got idx %0d expected no start", ifa.byte_idx);
               end else begin
                  e = qa.pop_front();
                  chk("a_tx_data", ifa.tx_data, e.b);
                  chk("a_byte_idx", ifa.byte_idx, e.idx);
               end
               if (ifa.byte_idx == 5'd0) begin
                  a_first = ifa.tx_data;
                  chk("a_accept_to_start", cyc - a_acc, 1);
               end else begin
                  chk("a_done_to_start", cyc - a_last_done, 1);
               end
               a_sc[ifa.byte_idx] = cyc;
               a_last = ifa.tx_data;
               a_hdata = ifa.tx_data;
               a_last_start = cyc;
            end else if (ifa.busy) begin
               chk("a_tx_data_hold", ifa.tx_data, a_hdata);
            end
            if (ifa.blk_done) begin
               a_bdone++;
               chk("a_done_to_blk_done", cyc - a_last_done, 1);
            end
            if (a_prev_bd) chk("a_ready_after_blk_done", ifa.blk_ready, 1'b1);
            a_prev_bd = ifa.blk_done;
            if (ifa.timeout_err && !a_prev_to) a_to_cyc = cyc;
            a_prev_to = ifa.timeout_err;
         end else begin
            a_prev_bd = 1'b0;
            a_prev_to = 1'b0;
         end
      end
   end

   // ---------------- transmitter model B ----------------
   int b_cnt = 0, b_last_done = -1;
   bit b_pend = 1'b0;

   initial begin
      ifb.tx_done = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            b_cnt = 0; b_pend = 1'b0; ifb.tx_done = 1'b0;
         end else begin
            if (ifb.tx_done) ifb.tx_done = 1'b0;
            else if (b_pend) begin
               ifb.tx_done = 1'b1;
               b_last_done = cyc;
               b_pend = 1'b0;
            end
            if (b_cnt > 0) begin
               b_cnt--;
               if (b_cnt == 0) b_pend = 1'b1;
            end
            if (ifb.tx_start) b_cnt = 9;
         end
      end
   end

   // ---------------- monitor B ----------------
   int b_starts = 0, b_bdone = 0, b_acc = -1;
   logic [7:0] b_first = '0, b_last = '0, b_hdata = '0;

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (ifb.tx_start) begin
               b_starts++;
               if (qb.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL b_unexpected_start: got idx %0d expected no start", ifb.byte_idx);
               end else begin
                  e = qb.pop_front();
                  chk("b_tx_data", ifb.tx_data, e.b);
                  chk("b_byte_idx", ifb.byte_idx, e.idx);
               end
               if (ifb.byte_idx == 5'd0) begin
                  b_first = ifb.tx_data;
                  chk("b_accept_to_start", cyc - b_acc, 1);
               end else begin
                  chk("b_done_to_start", cyc - b_last_done, 1 + GAP_B);
               end
               b_last = ifb.tx_data;
               b_hdata = ifb.tx_data;
            end else if (ifb.busy) begin
               chk("b_tx_data_hold", ifb.tx_data, b_hdata);
            end
            if (ifb.blk_done) b_bdone++;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic send_a(input logic [127:0] d, input int nexp);
      int n = 0;
      exp_t e;
      while (!ifa.blk_ready && n < 2000) begin @(negedge clk); n++; end
      ifa.blk_data  = d;
      ifa.blk_valid = 1'b1;
      a_acc = cyc;
      for (int k = 0; k < nexp; k++) begin
         e.b   = d[8*(NB-1-k) +: 8];
         e.idx = 5'(k);
         qa.push_back(e);
      end
      @(negedge clk);
      ifa.blk_valid = 1'b0;
   endtask

   task automatic send_b(input logic [127:0] d);
      int n = 0;
      exp_t e;
      while (!ifb.blk_ready && n < 2000) begin @(negedge clk); n++; end
      ifb.blk_data  = d;
      ifb.blk_valid = 1'b1;
      b_acc = cyc;
      for (int k = 0; k < NB; k++) begin
         e.b   = d[8*k +: 8];
         e.idx = 5'(k);
         qb.push_back(e);
      end
      @(negedge clk);
      ifb.blk_valid = 1'b0;
   endtask

   task automatic reset_vals_a();
      chk("rst_blk_ready", ifa.blk_ready, 1'b1);
      chk("rst_tx_start", ifa.tx_start, 1'b0);
      chk("rst_tx_data", ifa.tx_data, 8'h00);
      chk("rst_busy", ifa.busy, 1'b0);
      chk("rst_byte_idx", ifa.byte_idx, 5'd0);
      chk("rst_blk_done", ifa.blk_done, 1'b0);
      chk("rst_timeout_err", ifa.timeout_err, 1'b0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int s0, b0, n;
      ifa.blk_valid = 1'b0; ifa.blk_data = '0;
      ifb.blk_valid = 1'b0; ifb.blk_data = '0;

      vecs[0] = '{128'h00112233445566778899AABBCCDDEEFF, 99, 1'b0, 16, 1, 1'b0, 8'h00, 8'hFF};
      vecs[1] = '{128'h0123456789ABCDEFFEDCBA9876543210, 99, 1'b1, 16, 1, 1'b0, 8'h01, 8'h10};
      vecs[2] = '{128'h00112233445566778899AABBCCDDEEFF,  5, 1'b0,  6, 0, 1'b1, 8'h00, 8'h55};
      vecs[3] = '{128'hDEADBEEFCAFEF00D123456789ABCDEF0, 99, 1'b0, 16, 1, 1'b0, 8'hDE, 8'hF0};

      repeat (2) @(negedge clk);
      reset_vals_a();
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 4; i++) begin
         a_drop = vecs[i].drop;
         a_held = vecs[i].held;
         s0 = a_starts;
         b0 = a_bdone;
         send_a(vecs[i].data, vecs[i].exp_starts);
         n = 0;
         while (ifa.busy && n < 3000) begin @(negedge clk); n++; end
         chk("a_block_ends", ifa.busy, 1'b0);
         repeat (20) @(negedge clk);
         chk("a_start_count", a_starts - s0, vecs[i].exp_starts);
         chk("a_blk_done_count", a_bdone - b0, vecs[i].exp_done);
         chk("a_timeout_err", ifa.timeout_err, vecs[i].exp_to);
         chk("a_blk_ready_end", ifa.blk_ready, 1'b1);
         chk("a_queue_drained", qa.size(), 0);
         chk("a_first_byte", a_first, vecs[i].exp_first);
         chk("a_last_byte", a_last, vecs[i].exp_last);
         if (vecs[i].held) chk("a_held_done_spacing", a_sc[2] - a_sc[1], 21);
         if (vecs[i].exp_to) chk("a_timeout_cycle", a_to_cyc - a_last_start, TO_A + 1);
         qa.delete();
         a_drop = 99;
         a_held = 1'b0;
      end

      send_b(128'h00112233445566778899AABBCCDDEEFF);
      n = 0;
      while (ifb.busy && n < 3000) begin @(negedge clk); n++; end
      chk("b_block_ends", ifb.busy, 1'b0);
      repeat (5) @(negedge clk);
      chk("b_start_count", b_starts, 16);
      chk("b_blk_done_count", b_bdone, 1);
      chk("b_first_byte", b_first, 8'hFF);
      chk("b_last_byte", b_last, 8'h00);
      chk("b_queue_drained", qb.size(), 0);

      send_a(vecs[0].data, NB);
      n = 0;
      while (!(ifa.byte_idx == 5'd7 && ifa.busy && !ifa.tx_start) && n < 3000) begin
         @(negedge clk); n++;
      end
      chk("a_reached_byte7_wait", ifa.byte_idx, 5'd7);
      rst_n = 1'b0;
      #1;
      reset_vals_a();
      qa.delete();
      @(negedge clk);
      rst_n = 1'b1;
      s0 = a_starts;
      repeat (30) @(negedge clk);
      chk("a_no_start_after_reset", a_starts - s0, 0);
      chk("a_ready_after_reset", ifa.blk_ready, 1'b1);
      chk("a_idle_after_reset", ifa.busy, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
